// File: rtl/mem_byte_access_unit.sv
// ---------------------------------------------------------------------------
// mem_byte_access_unit
//
// Load/store sequencer between the MEM-stage pipeline and a byte-wide
// synchronous data memory. Byte, halfword and word accesses are split into
// one-byte memory beats, most significant byte first (big-endian). Load bytes
// are assembled into a 32-bit result.
//
// Optional feature macro: MISALIGN_CHECK_EN
//   defined   : misaligned halfword/word requests return rsp_err, no beats
//   undefined : misaligned requests are aligned down and proceed normally
//   (size 2'b11 is always rejected with rsp_err)
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   req_valid/ready    request handshake; ready only while idle
//   req_we             1 = store, 0 = load
//   req_size           00 byte, 01 halfword, 10 word, 11 illegal
//   req_addr           byte address (ADDR_W bits)
//   req_wdata          store data, right-justified
//   mem_en/we          memory beat strobe / write strobe
//   mem_addr/wdata     beat byte address / beat write byte
//   mem_rdata          read byte, valid the cycle after a read beat
//   rsp_valid/ready    response handshake, outputs held until accepted
//   rsp_err            misaligned (when checked) or illegal size
//   word_data          halfword/word load result, zero-extended
//   byte_data          byte load result
//   byte_sel           1 = consumer selects byte_data
// ---------------------------------------------------------------------------
module mem_byte_access_unit #(
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_err,
   output logic [31:0]       word_data,
   output logic [7:0]        byte_data,
   output logic              byte_sel
);

   typedef enum logic [1:0] {
      IDLE,
      BEAT,
      DRAIN,
      RSP
   } state_e;

   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [31:0]         wdata_q, wdata_d;   // store data, left-justified
   logic [1:0]          k_q, k_d;           // current beat index
   logic [1:0]          last_q, last_d;     // index of final beat (N-1)
   logic                err_q, err_d;
   logic [31:0]         rdata_q, rdata_d;   // assembled load result

   // Request decode: beat count, aligned base, error, and store data moved
   // to the top byte lanes so every beat can simply take bits [31:24].
   logic                req_err;
   logic [1:0]          req_last;
   logic [ADDR_W-1:0]   req_base;
   logic [31:0]         req_wjust;

   always_comb begin : decode
      req_err   = 1'b0;
      req_last  = 2'd0;
      req_base  = req_addr;
      req_wjust = {req_wdata[7:0], 24'h000000};
      case (req_size)
         2'b01: begin
            req_last  = 2'd1;
            req_wjust = {req_wdata[15:0], 16'h0000};
`ifdef MISALIGN_CHECK_EN
            req_err   = req_addr[0];
`else
            req_base  = {req_addr[ADDR_W-1:1], 1'b0};
`endif
         end
         2'b10: begin
            req_last  = 2'd3;
            req_wjust = req_wdata;
`ifdef MISALIGN_CHECK_EN
            req_err   = (req_addr[1:0] != 2'b00);
`else
            req_base  = {req_addr[ADDR_W-1:2], 2'b00};
`endif
         end
         2'b11: begin
            req_err   = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         base_q  <= '0;
         wdata_q <= '0;
         k_q     <= 2'd0;
         last_q  <= 2'd0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         base_q  <= base_d;
         wdata_q <= wdata_d;
         k_q     <= k_d;
         last_q  <= last_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // All outputs decode from the registered state, so an asynchronous reset
   // drops the strobes immediately.
   always_comb begin : fsm
      state_d   = state_q;
      we_d      = we_q;
      size_d    = size_q;
      base_d    = base_q;
      wdata_d   = wdata_q;
      k_d       = k_q;
      last_d    = last_q;
      err_d     = err_q;
      rdata_d   = rdata_q;

      req_ready = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      word_data = '0;
      byte_data = '0;
      byte_sel  = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               base_d  = req_base;
               wdata_d = req_wjust;
               last_d  = req_last;
               err_d   = req_err;
               k_d     = 2'd0;
               rdata_d = '0;
               state_d = req_err ? RSP : BEAT;
            end
         end

         BEAT: begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = base_q + ADDR_W'(k_q);
            mem_wdata = we_q ? wdata_q[31:24] : 8'h00;
            wdata_d   = {wdata_q[23:0], 8'h00};
            k_d       = k_q + 2'd1;
            // Read data lags its beat by one cycle: beat k collects byte k-1.
            if (!we_q && (k_q != 2'd0)) begin
               rdata_d = {rdata_q[23:0], mem_rdata};
            end
            if (k_q == last_q) begin
               state_d = we_q ? RSP : DRAIN;
            end
         end

         DRAIN: begin
            rdata_d = {rdata_q[23:0], mem_rdata};
            state_d = RSP;
         end

         RSP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            if (!err_q && !we_q) begin
               if (size_q == 2'b00) begin
                  byte_sel  = 1'b1;
                  byte_data = rdata_q[7:0];
               end else begin
                  word_data = rdata_q;
               end
            end
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_byte_access_unit.sv
module tb_mem_byte_access_unit;

   localparam int unsigned AW = 9;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [1:0]    req_size;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_err;
   logic [31:0]   word_data;
   logic [7:0]    byte_data;
   logic          byte_sel;

   int unsigned   checks = 0;
   int unsigned   errors = 0;

   // mem: the memory the DUT talks to; ref_mem: the bench's own model of
   // what memory should contain, updated from store requests.
   logic [7:0]    mem     [512];
   logic [7:0]    ref_mem [512];
   logic          preload;

   always #5 clk = ~clk;

   mem_byte_access_unit #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_err   (rsp_err),
      .word_data (word_data),
      .byte_data (byte_data),
      .byte_sel  (byte_sel)
   );

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 512; i++) mem[i] <= ref_mem[i];
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_mem_en"},    32'(mem_en),    32'd0);
      chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
      chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
      chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
      chk({tag, "_word_data"}, word_data,      32'd0);
      chk({tag, "_byte_data"}, 32'(byte_data), 32'd0);
      chk({tag, "_byte_sel"},  32'(byte_sel),  32'd0);
   endtask

   // One complete access: expectations come from the access rules
   // (beat count, alignment, big-endian byte order, latency) and ref_mem.
   task automatic access(input logic we, input logic [1:0] size, input logic [AW-1:0] addr,
                         input logic [31:0] wd, input int unsigned hold);
      int unsigned   n, lat, cyc, beats;
      logic          err, got, exp_sel;
      logic [AW-1:0] base;
      logic [31:0]   exp_word;
      logic [7:0]    exp_byte;

      n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      err  = (size == 2'b11);
      base = addr;
      if (!err) begin
`ifdef MISALIGN_CHECK_EN
         if ((32'(addr) % n) != 0) err = 1'b1;
`else
         base = AW'(32'(addr) - (32'(addr) % n));
`endif
      end
      lat      = err ? 1 : (we ? n + 1 : n + 2);
      exp_sel  = !err && !we && (n == 1);
      exp_byte = exp_sel ? ref_mem[base] : 8'h00;
      exp_word = 32'd0;
      if (!err && !we && n > 1) begin
         for (int unsigned k = 0; k < n; k++)
            exp_word = (exp_word << 8) | 32'(ref_mem[AW'(32'(base) + k)]);
      end

      @(negedge clk);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_size  = size;
      req_addr  = addr;
      req_wdata = wd;

      cyc   = 0;
      beats = 0;
      got   = 1'b0;
      while (!got && cyc < 12) begin
         @(negedge clk);
         cyc++;
         // Scramble request inputs after acceptance: the unit must use its copy.
         req_valid = 1'b0;
         req_we    = 1'($urandom);
         req_size  = 2'($urandom);
         req_addr  = AW'($urandom);
         req_wdata = $urandom;
         if (cyc == 1) chk("req_ready_busy", 32'(req_ready), 32'd0);
         if (mem_en) begin
            chk("beat_cycle", cyc, beats + 1);
            chk("beat_addr", 32'(mem_addr), 32'(AW'(32'(base) + beats)));
            chk("beat_we", 32'(mem_we), 32'(we));
            if (we) chk("beat_wdata", 32'(mem_wdata), (wd >> (8 * (n - 1 - beats))) & 32'hFF);
            beats++;
         end
         if (rsp_valid) got = 1'b1;
      end
      chk("rsp_seen", 32'(got), 32'd1);
      chk("rsp_latency", cyc, lat);
      chk("beat_count", beats, err ? 0 : n);

      for (int unsigned h = 0; h <= hold; h++) begin
         if (h > 0) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_size  = 2'b00;
            req_addr  = AW'($urandom);
            @(negedge clk);
            chk("hold_no_beat", 32'(mem_en), 32'd0);
         end
         chk("rsp_valid", 32'(rsp_valid), 32'd1);
         chk("rsp_err", 32'(rsp_err), 32'(err));
         chk("word_data", word_data, exp_word);
         chk("byte_data", 32'(byte_data), 32'(exp_byte));
         chk("byte_sel", 32'(byte_sel), 32'(exp_sel));
         chk("req_ready_rsp", 32'(req_ready), 32'd0);
      end

      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("req_ready_after", 32'(req_ready), 32'd1);
      chk("rsp_valid_after", 32'(rsp_valid), 32'd0);

      if (we && !err) begin
         for (int unsigned k = 0; k < n; k++)
            ref_mem[AW'(32'(base) + k)] = 8'(wd >> (8 * (n - 1 - k)));
      end
   endtask

   initial begin
      logic [AW-1:0] rst_addr;

      rst_n     = 1'b1;
      preload   = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_size  = 2'b00;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 512; i++) ref_mem[i] = 8'($urandom);
      ref_mem[16] = 8'h12;
      ref_mem[17] = 8'h34;
      ref_mem[18] = 8'h56;
      ref_mem[19] = 8'h78;

      #1 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_idle_outputs("reset");
      preload = 1'b0;
      rst_n   = 1'b1;
      @(negedge clk);
      chk_idle_outputs("post_reset");

      // Directed accesses from the access examples.
      access(1'b0, 2'b10, 9'h010, 32'h0, 0);          // word 0x12345678
      access(1'b0, 2'b00, 9'h012, 32'h0, 0);          // byte 0x56
      access(1'b0, 2'b01, 9'h012, 32'h0, 0);          // halfword 0x5678
      access(1'b1, 2'b10, 9'h020, 32'hCAFEBABE, 0);   // word store
      access(1'b0, 2'b10, 9'h020, 32'h0, 1);          // reload
      access(1'b0, 2'b10, 9'h021, 32'h0, 0);          // misaligned word
      access(1'b1, 2'b01, 9'h033, 32'h1234ABCD, 0);   // misaligned halfword store
      access(1'b0, 2'b11, 9'h010, 32'h0, 0);          // illegal size
      access(1'b1, 2'b00, 9'h1FF, 32'hFFFFFFA5, 0);   // byte store, top address
      access(1'b0, 2'b10, 9'h010, 32'h0, 5);          // response back-pressure

      for (int i = 0; i < 40; i++)
         access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), AW'($urandom),
                $urandom, $urandom_range(0, 2));

      // Reset in the middle of a word load (third beat).
`ifdef MISALIGN_CHECK_EN
      rst_addr = 9'h1FC;
`else
      rst_addr = 9'h1FE;
`endif
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = 2'b10;
      req_addr  = rst_addr;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_beat2_en", 32'(mem_en), 32'd1);
      chk("rst_beat2_addr", 32'(mem_addr), 32'h1FE);
      #2 rst_n = 1'b0;
      #1;
      chk_idle_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle_outputs("reset_release");
      access(1'b0, 2'b10, 9'h010, 32'h0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_byte_access_unit.md
# mem_byte_access_unit

Sequential load/store unit between the MEM-stage pipeline and a byte-wide synchronous data memory. It serialises byte, halfword and word accesses into single-byte memory beats (big-endian, PA-RISC order) and assembles load results. It drives the downstream 32-bit result selector: the 32-bit word/halfword value on `word_data`, the raw byte on `byte_data`, and the select on `byte_sel`.

## Interface
Parameters:
- `ADDR_W`, 9: byte-address width of the data memory.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `mem_en`  out  1  memory beat strobe.
- `mem_we`  out  1  write strobe, valid with `mem_en`.
- `mem_addr`  out  ADDR_W  beat byte address.
- `mem_wdata`  out  8  beat write byte.
- `mem_rdata`  in  8  read byte, valid the cycle after the read beat.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_err`  out  1  misaligned or illegal size.
- `word_data`  out  32  load result, zero-extended for halfword.
- `byte_data`  out  8  byte load result.
- `byte_sel`  out  1  1 = consumer selects `byte_data`.

## Operation
- States: IDLE, BEAT, DRAIN, RSP. Reset: IDLE; every output 0 except `req_ready` = 1.
- `req_ready` = 1 only in IDLE. Accept on `req_valid & req_ready`; latch we, size, addr, wdata; beat count N = 1/2/4.
- IDLE -> BEAT on accept; IDLE -> RSP with `rsp_err` = 1 on error (no memory beat).
- BEAT: `mem_en` = 1, `mem_addr` = base + k, k = 0..N-1, one per cycle. Address arithmetic wraps modulo 2^ADDR_W.
- Store beats: byte k = bits [8(N-1-k)+7 : 8(N-1-k)] of `req_wdata` (MSB first). Last beat -> RSP.
- Load beats: byte returned for beat k shifts into `word_data` from the LSB end (shift left 8). Last beat -> DRAIN (capture final byte) -> RSP.
- RSP: `rsp_valid` = 1; outputs held stable until `rsp_ready`; then -> IDLE. Byte load: `byte_sel` = 1, `byte_data` = byte, `word_data` = 0. Halfword/word load: `byte_sel` = 0, `byte_data` = 0. Store or error: data outputs 0, `byte_sel` = 0.
- `rst_n` low at any time: immediate return to IDLE, `mem_en`/`mem_we`/`rsp_valid` drop asynchronously; in-flight access abandoned (partial stores not rolled back).

## Timing
- Accept in cycle T. Beat k in cycle T+1+k.
- Load: `rsp_valid` from cycle T+N+2 (byte T+3, halfword T+4, word T+6).
- Store: `rsp_valid` from cycle T+N+1 (byte T+2, word T+5).
- Error: `rsp_valid` from cycle T+1.
- Response handshake in cycle R -> `req_ready` = 1 in R+1; back-to-back throughput one access per N+3 cycles (load).
- `req_valid` while busy is ignored, not queued.

## Configuration
- `MISALIGN_CHECK_EN` defined: halfword with `req_addr[0]` = 1, word with `req_addr[1:0]` != 0, or size 11 -> error response, no beats.
- Not defined: size 11 still errors; misaligned addresses silently aligned down (low bits cleared), access proceeds, `rsp_err` never set for alignment.

## Test plan
- Memory [0x10..0x13] = 12 34 56 78; word load addr 0x10 -> beats 0x10..0x13 cycles T+1..T+4, `rsp_valid` at T+6, `word_data` = 0x12345678, `byte_sel` = 0.
- Byte load addr 0x12 -> `rsp_valid` at T+3, `byte_data` = 0x56, `byte_sel` = 1, `word_data` = 0; halfword load 0x12 -> `word_data` = 0x00005678.
- Word store 0xCAFEBABE at 0x20 -> `mem_wdata` CA,FE,BA,BE at 0x20..0x23 with `mem_we` = 1, `rsp_valid` at T+5; reload returns 0xCAFEBABE.
- Word load addr 0x21: with `MISALIGN_CHECK_EN`, `rsp_err` = 1 at T+1, `mem_en` never asserted; without, beats 0x20..0x23.
- Hold `rsp_ready` = 0 for 5 cycles -> outputs stable, `req_ready` = 0, new `req_valid` ignored; release -> `req_ready` = 1 next cycle.
- Word load at addr 0x1FE (ADDR_W = 9, check disabled, aligned to 0x1FC); assert `rst_n` = 0 during beat 2 -> `mem_en` drops immediately, all outputs reset values, `req_ready` = 1 after release.
